// File: rtl/keccak_sponge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_sponge_ctrl
//  Description : Sponge-mode controller for a Keccak permutation core. Packs
//                input words into a rate-sized block, applies SHA-3 padding
//                (0x06 ... 0x80), sequences absorb/final permutations and
//                returns the digest over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_sponge_ctrl #(
   parameter int L = 6,    // lane-size exponent, b = 25*2^L
   parameter int D = 112,  // digest width in bits, c = 2*D
   parameter int W = 32    // input word width
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [W-1:0]                  in_data,
   input  logic                          in_last,
   input  logic [$clog2(W/8+1)-1:0]      in_nbytes,
   output logic                          core_enable,
   output logic                          core_reset,
   output logic [(25 << L)-2*D-1:0]      core_message,
   input  logic [D-1:0]                  core_digest,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [D-1:0]                  out_digest,
   output logic                          busy
);

   localparam int c_b      = 25 << L;
   localparam int c_r      = c_b - 2*D;
   localparam int c_rw     = c_r / W;
   localparam int c_nb     = W / 8;
   localparam int c_nbw    = $clog2(c_nb + 1);
   localparam int c_rbytes = c_r / 8;
   localparam int c_wcw    = (c_rw > 1) ? $clog2(c_rw) : 1;
   localparam int c_biw    = $clog2(c_rbytes + 1);

   localparam logic [2:0] c_st_fill   = 3'd0;
   localparam logic [2:0] c_st_absorb = 3'd1;
   localparam logic [2:0] c_st_final  = 3'd2;
   localparam logic [2:0] c_st_done   = 3'd3;
   localparam logic [2:0] c_st_clear  = 3'd4;

   localparam logic [c_wcw-1:0] c_wc_last  = c_wcw'(c_rw - 1);
   localparam logic [c_nbw-1:0] c_nb_full  = c_nbw'(c_nb);
   // Block holding only padding: domain bits 0x06 in byte 0, 0x80 in the last byte.
   localparam logic [c_r-1:0]   c_pad_block = {8'h80, {(c_r-16){1'b0}}, 8'h06};

   logic [2:0]        r_state;
   logic [c_wcw-1:0]  r_wc;
   logic [c_r-1:0]    r_buf;
   logic              r_pad_pending;
   logic [D-1:0]      r_out_digest;

   logic              w_accept;
   logic [c_nbw-1:0]  w_nb;
   logic              w_full_last;
   logic [c_biw-1:0]  w_base;
   logic [c_biw-1:0]  w_end;
   logic [c_r-1:0]    w_word_buf;
   logic [c_r-1:0]    w_last_buf;

   assign in_ready     = reset & (r_state == c_st_fill);
   assign w_accept     = in_valid & in_ready;
   assign core_enable  = (r_state == c_st_absorb) | (r_state == c_st_final);
   assign core_reset   = ~reset | (r_state == c_st_clear);
   assign core_message = r_buf;
   assign out_valid    = (r_state == c_st_done);
   assign out_digest   = r_out_digest;
   assign busy         = ~((r_state == c_st_fill) && (r_wc == '0));

   // Byte counts above a full word are treated as a full word.
   assign w_nb        = (in_nbytes > c_nb_full) ? c_nb_full : in_nbytes;
   // Final word fills the block exactly: padding needs a block of its own.
   assign w_full_last = (r_wc == c_wc_last) && (w_nb == c_nb_full);
   // Byte offset of the current word and of the first byte past the message.
   assign w_base      = c_biw'(r_wc) * c_biw'(c_nb);
   assign w_end       = w_base + c_biw'(w_nb);

   // Plain word write: only word wc of the buffer is replaced.
   for (genvar j = 0; j < c_rw; j++) begin : g_word
      assign w_word_buf[W*j +: W] = (r_wc == c_wcw'(j)) ? in_data : r_buf[W*j +: W];
   end

   // Final-word write with in-block padding, built byte by byte.
   for (genvar k = 0; k < c_rbytes; k++) begin : g_byte
      localparam logic [c_biw-1:0] c_k    = c_biw'(k);
      localparam logic [7:0]       c_tail = (k == c_rbytes - 1) ? 8'h80 : 8'h00;
      logic [7:0] w_data;

      // Keep earlier words, take valid bytes of this word, zero everything after.
      always_comb begin
         if (c_k < w_base)
            w_data = r_buf[8*k +: 8];
         else if (c_k < w_end)
            w_data = in_data[8*(k % c_nb) +: 8];
         else
            w_data = 8'h00;
      end

      assign w_last_buf[8*k +: 8] = w_data ^ ((c_k == w_end) ? 8'h06 : 8'h00) ^ c_tail;
   end

   // Sponge sequencing: fill block, absorb, pad/final, hold digest, clear core.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= c_st_fill;
         r_wc          <= '0;
         r_buf         <= '0;
         r_pad_pending <= 1'b0;
         r_out_digest  <= '0;
      end else begin
         case (r_state)
            c_st_fill: begin
               if (w_accept) begin
                  if (in_last && w_full_last) begin
                     r_buf         <= w_word_buf;
                     r_pad_pending <= 1'b1;
                     r_wc          <= '0;
                     r_state       <= c_st_absorb;
                  end else if (in_last) begin
                     r_buf   <= w_last_buf;
                     r_wc    <= '0;
                     r_state <= c_st_final;
                  end else begin
                     r_buf <= w_word_buf;
                     if (r_wc == c_wc_last) begin
                        r_wc    <= '0;
                        r_state <= c_st_absorb;
                     end else begin
                        r_wc <= r_wc + 1'b1;
                     end
                  end
               end
            end
            c_st_absorb: begin
               if (r_pad_pending) begin
                  r_buf         <= c_pad_block;
                  r_pad_pending <= 1'b0;
                  r_state       <= c_st_final;
               end else begin
                  r_buf   <= '0;
                  r_state <= c_st_fill;
               end
            end
            c_st_final: begin
               r_out_digest <= core_digest;
               r_state      <= c_st_done;
            end
            c_st_done: begin
               if (out_ready)
                  r_state <= c_st_clear;
            end
            c_st_clear: begin
               r_buf   <= '0;
               r_wc    <= '0;
               r_state <= c_st_fill;
            end
            default: begin
               r_buf         <= '0;
               r_wc          <= '0;
               r_pad_pending <= 1'b0;
               r_state       <= c_st_fill;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/keccak_sponge_ctrl.md
KECCAK_SPONGE_CTRL -- requirements
Module: keccak_sponge_ctrl

Interface
REQ-001 Parameter: l, 6, Keccak lane-size exponent; permutation width b = 25*2^l.
REQ-002 Parameter: d, 112, digest width in bits; capacity c = 2*d; rate r = b - c.
REQ-003 Parameter: W, 32, input word width; r % W == 0 and W % 8 == 0; RW = r/W words per block; NB = W/8.
REQ-004 Port: clk  in  1  single clock, rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: in_valid  in  1  input word valid.
REQ-007 Port: in_ready  out  1  controller accepts a word when in_valid & in_ready.
REQ-008 Port: in_data  in  W  message word; byte k at bits [8k+7:8k].
REQ-009 Port: in_last  in  1  final word of message.
REQ-010 Port: in_nbytes  in  clog2(NB+1)  valid bytes in last word, 0..NB; ignored when in_last=0.
REQ-011 Port: core_enable  out  1  one-permutation enable to keccak core.
REQ-012 Port: core_reset  out  1  active-high clear of keccak core state.
REQ-013 Port: core_message  out  r  rate block to core; word j at bits [W*j+W-1:W*j].
REQ-014 Port: core_digest  in  d  combinational digest from core (valid in cycle core_enable=1).
REQ-015 Port: out_valid / out_ready / out_digest  out/in/out  1/1/d  digest handshake.
REQ-016 Port: busy  out  1  high in any state other than FILL with word count 0.

Function
REQ-017 States SHALL be FILL, ABSORB, FINAL, DONE, CLEAR; word counter wc in 0..RW-1; block buffer buf (r bits) drives core_message.
REQ-018 FILL: in_ready=1; accepted word written to buf word wc; wc increments.
REQ-019 FILL, accepted in_last=0 at wc=RW-1: wc->0, next ABSORB.
REQ-020 FILL, accepted in_last=1 with data ending before block end (wc<RW-1, or nbytes<NB): bytes beyond nbytes in that word and all later words zeroed; byte (wc*NB+nbytes) ^= 0x06; byte r/8-1 ^= 0x80 (same byte gives 0x86); next FINAL.
REQ-021 FILL, accepted in_last=1, nbytes=NB at wc=RW-1: set pad_pending; next ABSORB.
REQ-022 ABSORB (1 cycle): core_enable=1, in_ready=0; next cycle buf cleared; if pad_pending, buf loaded with byte0=0x06, byte r/8-1=0x80, rest zero, pad_pending cleared, next FINAL; else next FILL.
REQ-023 FINAL (1 cycle): core_enable=1; out_digest <= core_digest at end of cycle; next DONE.
REQ-024 DONE: out_valid=1, out_digest stable until out_valid & out_ready; then next CLEAR.
REQ-025 CLEAR (1 cycle): core_reset=1, buf and wc cleared; next FILL.
REQ-026 in_ready=0 in ABSORB, FINAL, DONE, CLEAR; core_enable=0 in FILL, DONE, CLEAR.
REQ-027 Latency: out_valid rises exactly 1 cycle after FINAL; each full block costs one ABSORB cycle; max throughput one word per cycle in FILL.
REQ-028 Empty message (in_last=1, nbytes=0 at wc=0): single padded block 0x06..0x80.
REQ-029 in_valid with in_ready=0 SHALL have no effect; input stall at any wc preserves buf.

Reset
REQ-030 reset low asynchronously: state FILL, wc=0, buf=0, pad_pending=0, out_valid=0, out_digest=0, core_enable=0, in_ready=0 while reset low.
REQ-031 core_reset=1 while reset low; reset mid-message discards all partial data and digest.

Verification (run with d=256: r=1088, RW=34, W=32)
REQ-032 Empty message -> one FINAL cycle, out_digest bytes 0..3 = a7 ff c6 f8 (SHA3-256 "" = a7ffc6f8...8434a).
REQ-033 "abc": one word 0x00636261, in_last=1, nbytes=3 -> core_message byte3=0x06, byte135=0x80; digest 3a985da7...11431532.
REQ-034 136-byte message (34 full words, last flagged nbytes=4) -> ABSORB then FINAL with pad-only block; exactly 2 core_enable pulses.
REQ-035 135-byte message -> byte 135 = 0x86 in single FINAL block.
REQ-036 out_ready held low 10 cycles -> out_valid and out_digest stable, in_ready=0; after handshake one core_reset pulse, then in_ready=1.
REQ-037 reset asserted during FILL at wc=17 -> immediate in_ready=0, core_reset=1; next message after release hashes correctly.
